// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, DIV opcode and counter sizing for seq_divider
package div_pkg;
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
    localparam logic [4:0] DIV_OPCODE = 5'b10000;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional two's-complement negate
module div_sign_fix #(parameter int WIDTH = 32) (
    input  logic             neg,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);
    assign y = neg ? -a : a;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring radix-2 divider with start/done handshake; DIV_SIGNED_EN enables signed mode
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = clog2(WIDTH);
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
    logic [WIDTH:0]   sh, trial;
    assign sh    = {rem, quo[WIDTH-1]};
    assign trial = sh - {1'b0, dvs};
`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;
    div_sign_fix #(.WIDTH(WIDTH)) u_a (.neg(signed_mode & dividend[WIDTH-1]), .a(dividend), .y(a_mag));
    div_sign_fix #(.WIDTH(WIDTH)) u_b (.neg(signed_mode & divisor[WIDTH-1]), .a(divisor), .y(b_mag));
    div_sign_fix #(.WIDTH(WIDTH)) u_q (.neg(neg_q), .a(quo), .y(q_fix));
    div_sign_fix #(.WIDTH(WIDTH)) u_r (.neg(neg_r), .a(rem), .y(r_fix));
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= signed_mode & dividend[WIDTH-1];
        end
    end
`else
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode;
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_fix = quo;
    assign r_fix = rem;
`endif
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy        <= 1'b1;
                    cnt         <= CW'(WIDTH - 1);
                    rem         <= '0;
                    quo         <= a_mag;
                    dvs         <= b_mag;
                    div_by_zero <= (divisor == '0);
                    quotient    <= (divisor == '0) ? '1 : '0;
                    remainder   <= (divisor == '0) ? dividend : '0;
                    done        <= (divisor == '0);
                    state       <= (divisor == '0) ? DONE : ITER;
                end
                ITER: begin
                    // negative trial keeps the shifted partial remainder
                    rem   <= trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    cnt   <= cnt - 1'b1;
                    state <= (cnt == '0) ? FIX : ITER;
                end
                FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle integer divider for the Mini-SRC ALU path, producing quotient (for LO) and remainder (for HI) from two WIDTH-bit operands. It replaces the single-step DIV (opcode 5'b10000) result with a restoring radix-2 engine that has a start/done handshake, signed and unsigned modes, and divide-by-zero detection. The control unit pulses start and waits for done before asserting Zlowin/Zhighin-equivalent captures.

## Interface
- WIDTH, 32, operand/result width (≥4)
- clock  in  1  rising-edge clock
- clear  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- dividend  in  WIDTH  sampled with start
- divisor  in  WIDTH  sampled with start
- busy  out  1  high from cycle after accepted start until done cycle inclusive
- done  out  1  one-cycle pulse, results valid
- quotient  out  WIDTH  to LO
- remainder  out  WIDTH  to HI
- div_by_zero  out  1  set with done when divisor was 0; held until next accepted start

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE: start=1 latches operands and mode; signed_mode=1 stores magnitudes plus sign flags (quotient sign = XOR, remainder sign = dividend sign); iteration counter = WIDTH-1. Divisor=0 → DONE directly, else → ITER.
- ITER: one quotient bit per cycle, MSB first: shift {rem,quo} left 1, trial = rem − divisor (WIDTH+1 bits); if non-negative keep trial and set quo LSB = 1. Counter 0 → FIX.
- FIX: negate quotient/remainder per sign flags; → DONE.
- DONE: done=1, results driven; → IDLE.
- Divide-by-zero: quotient = all ones, remainder = dividend (as sampled), div_by_zero=1.
- Signed rounding truncates toward zero; remainder sign follows dividend.
- Overflow most-negative ÷ −1: quotient = most-negative (wraps), remainder 0, no flag.
- quotient/remainder/div_by_zero hold after DONE until next accepted start; cleared to 0 on acceptance.
- start while busy: ignored, no queueing.

## Timing
- Reset: state IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0. Asserting clear mid-operation aborts immediately; no done is produced.
- Start accepted at edge E0; busy rises after E0.
- Normal latency: WIDTH cycles ITER + 1 FIX + 1 DONE; done high in cycle WIDTH+2 after E0 (34 for WIDTH=32).
- Divide-by-zero latency: done high in cycle 1 after E0.
- start may be reasserted in the cycle after done (IDLE).
- Latency independent of operand values and mode.

## Configuration
- DIV_SIGNED_EN defined: signed_mode honoured as above.
- Undefined: signed_mode ignored, all operations unsigned, sign flags and negators removed; FIX state retained as one idle cycle so latency is unchanged.

## Structure
- Shared package div_pkg: state enum (IDLE/ITER/FIX/DONE), DIV opcode constant 5'b10000, counter width function clog2(WIDTH).
- One sub-module div_sign_fix: combinational conditional two's-complement negate (used for operand magnitude and result fix-up), instantiated only under DIV_SIGNED_EN.

## Test plan
- Unsigned 23 ÷ 5, WIDTH=32 → done at cycle 34 after start, quotient 4, remainder 3, div_by_zero 0, busy high cycles 1–34.
- Signed −23 ÷ 5 → quotient 0xFFFFFFFC, remainder 0xFFFFFFFD; signed 23 ÷ −5 → quotient 0xFFFFFFFC, remainder 3.
- 23 ÷ 0 → done at cycle 1, quotient 0xFFFFFFFF, remainder 23, div_by_zero 1; flag clears on next accepted start.
- Signed 0x80000000 ÷ 0xFFFFFFFF → quotient 0x80000000, remainder 0; unsigned same operands → quotient 0, remainder 0x80000000.
- clear low at cycle 10 of an operation → busy/done/outputs 0 immediately, no done pulse; start at cycle 5 of an operation ignored (single done, original result).
- WIDTH=8, unsigned 200 ÷ 7 → done at cycle 10, quotient 28, remainder 4.
